// File: rtl/hid_key_matrix.sv
// Keyboard-matrix back end: queues decoded key events, applies them to a ROWS x COLS
// matrix read by the row scan, and dwells a few firmware scans after each key change.
`timescale 1ns/1ps
module hid_key_matrix #(
    parameter int ROWS       = 16,
    parameter int COLS       = 8,
    parameter int DEPTH      = 8,
    parameter int HOLD_SCANS = 2,
    localparam int RW        = $clog2(ROWS),
    localparam int CW        = $clog2(COLS),
    localparam int PW        = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ev_valid,
    input  logic            ev_press,
    input  logic [RW-1:0]   ev_row,
    input  logic [CW-1:0]   ev_col,
    output logic            ev_ready,
    input  logic            scan_tick,
    input  logic            release_all,
    input  logic [RW-1:0]   Y,
    output logic [COLS-1:0] X,
    output logic [PW-1:0]   pending,
    output logic            overflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int EW  = 1 + RW + CW;
    localparam int CTW = (HOLD_SCANS < 1) ? 1 : $clog2(HOLD_SCANS + 1);

    localparam logic [0:0]    IDLE    = 1'b0;
    localparam logic [0:0]    DWELL   = 1'b1;
    localparam logic [RW:0]   ROWS_L  = ROWS[RW:0];
    localparam logic [CTW-1:0] HOLD_LD = CTW'(HOLD_SCANS);

    logic [ROWS-1:0][COLS-1:0] matrix;
    logic [EW-1:0]             fifo_mem [DEPTH];
    logic [AW:0]               wr_ptr;
    logic [AW:0]               rd_ptr;
    logic [AW:0]               occ;
    logic                      empty;
    logic                      full;
    logic                      push;
    logic                      pop;
    logic [0:0]                state;
    logic [CTW-1:0]            dwell_cnt;

    logic                      head_press;
    logic [RW-1:0]             head_row;
    logic [CW-1:0]             head_col;
    logic                      head_row_ok;
    logic                      head_changes;

    // Extra pointer bit: occupancy never exceeds DEPTH, so its top bit flags full.
    assign occ      = wr_ptr - rd_ptr;
    assign empty    = (occ == '0);
    assign full     = occ[AW];
    assign pending  = occ;

    assign ev_ready = !full && !release_all;
    assign push     = ev_valid && ev_ready;
    assign pop      = (state == IDLE) && !empty && !release_all;

    assign {head_press, head_row, head_col} = fifo_mem[rd_ptr[AW-1:0]];

    // Out-of-range rows are consumed without touching the matrix or starting a dwell.
    assign head_row_ok  = ({1'b0, head_row} < ROWS_L);
    assign head_changes = head_row_ok && (matrix[head_row][head_col] != head_press);

    assign X = ({1'b0, Y} < ROWS_L) ? ~matrix[Y] : '1;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {ev_press, ev_row, ev_col};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            state     <= IDLE;
            dwell_cnt <= '0;
            overflow  <= 1'b0;
            matrix    <= '0;
        end else begin
            if (ev_valid && !ev_ready) begin
                overflow <= 1'b1;
            end
            if (release_all) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                state     <= IDLE;
                dwell_cnt <= '0;
                matrix    <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + (AW+1)'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + (AW+1)'(1);
                end
                case (state)
                    IDLE: begin
                        if (pop && head_changes) begin
                            matrix[head_row][head_col] <= head_press;
                            if (HOLD_SCANS > 0) begin
                                dwell_cnt <= HOLD_LD;
                                state     <= DWELL;
                            end
                        end
                    end
                    DWELL: begin
                        // A tick on the entry edge was seen in IDLE, so it never counts here.
                        if (scan_tick) begin
                            dwell_cnt <= dwell_cnt - CTW'(1);
                            if (dwell_cnt == CTW'(1)) begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hid_key_matrix.sv
// Bench for hid_key_matrix: directed scenarios plus a randomized run, all checked
// against an event-queue model of the matrix and its dwell rule.
`timescale 1ns/1ps
module tb_hid_key_matrix;

    localparam int ROWS       = 16;
    localparam int COLS       = 8;
    localparam int DEPTH      = 8;
    localparam int HOLD_SCANS = 2;
    localparam int RW         = $clog2(ROWS);
    localparam int CW         = $clog2(COLS);
    localparam int PW         = $clog2(DEPTH + 1);

    typedef struct packed {
        logic          p;
        logic [RW-1:0] r;
        logic [CW-1:0] c;
    } ev_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            ev_valid;
    logic            ev_press;
    logic [RW-1:0]   ev_row;
    logic [CW-1:0]   ev_col;
    logic            ev_ready;
    logic            scan_tick;
    logic            release_all;
    logic [RW-1:0]   Y;
    logic [COLS-1:0] X;
    logic [PW-1:0]   pending;
    logic            overflow;

    always #25 clk = ~clk;

    hid_key_matrix #(
        .ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH), .HOLD_SCANS(HOLD_SCANS)
    ) dut (
        .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_press(ev_press),
        .ev_row(ev_row), .ev_col(ev_col), .ev_ready(ev_ready),
        .scan_tick(scan_tick), .release_all(release_all), .Y(Y), .X(X),
        .pending(pending), .overflow(overflow)
    );

    // Reference model: key states, queued events, scans still to wait, sticky overflow.
    logic [COLS-1:0] m_mat [ROWS];
    ev_t             m_q[$];
    int              m_dwell;
    bit              m_ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic cycle();
        ev_t e;
        bit  ready;
        bit  do_pop;
        if (reset) begin
            m_q.delete();
            for (int i = 0; i < ROWS; i++) m_mat[i] = '0;
            m_dwell = 0;
            m_ovf   = 1'b0;
        end else if (release_all) begin
            m_q.delete();
            for (int i = 0; i < ROWS; i++) m_mat[i] = '0;
            m_dwell = 0;
            if (ev_valid) m_ovf = 1'b1;
        end else begin
            ready  = (m_q.size() < DEPTH);
            do_pop = (m_dwell == 0) && (m_q.size() != 0);
            if (m_dwell > 0 && scan_tick) m_dwell--;
            if (do_pop) begin
                e = m_q.pop_front();
                if (int'(e.r) < ROWS && m_mat[e.r][e.c] != e.p) begin
                    m_mat[e.r][e.c] = e.p;
                    m_dwell = HOLD_SCANS;
                end
            end
            if (ev_valid) begin
                if (ready) begin
                    e.p = ev_press;
                    e.r = ev_row;
                    e.c = ev_col;
                    m_q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        reset       = 1'b0;
        ev_valid    = 1'b0;
        scan_tick   = 1'b0;
        release_all = 1'b0;
        #1;
    endtask

    task automatic offer(input int r, input int c, input bit p);
        ev_valid = 1'b1;
        ev_row   = RW'(r);
        ev_col   = CW'(c);
        ev_press = p;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (pending !== '0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", pending); end
        n_cmp++;
        if (ev_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ev_ready); end
        n_cmp++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        for (int r = 0; r < ROWS; r++) begin
            Y = RW'(r); #1;
            n_cmp++;
            if (X !== 8'hFF) begin n_fail++; $display("FAIL reset_X row %0d: got %h want ff", r, X); end
        end
    endtask

    task automatic test_single_press();
        do_reset();
        offer(8, 5, 1'b1);
        cycle();
        Y = 4'd8; #1;
        n_cmp++;
        if (pending !== PW'(1)) begin n_fail++; $display("FAIL single_pend_accept: got %0d want 1", pending); end
        n_cmp++;
        if (X !== 8'hFF) begin n_fail++; $display("FAIL single_X_early: got %h want ff", X); end
        cycle();
        n_cmp++;
        if (pending !== '0) begin n_fail++; $display("FAIL single_pend_pop: got %0d want 0", pending); end
        for (int r = 0; r < ROWS; r++) begin
            Y = RW'(r); #1;
            n_cmp++;
            if (X !== ((r == 8) ? 8'hDF : 8'hFF)) begin
                n_fail++;
                $display("FAIL single_X row %0d: got %h want %h", r, X, (r == 8) ? 8'hDF : 8'hFF);
            end
        end
    endtask

    task automatic test_dwell_pacing();
        do_reset();
        Y = 4'd5;
        offer(5, 7, 1'b1);
        cycle();
        offer(5, 7, 1'b0);
        cycle();
        // Press applied; release queued behind the dwell. Ticks land in steps 2 and 4.
        for (int s = 0; s < 5; s++) begin
            n_cmp++;
            if (X !== 8'h7F) begin n_fail++; $display("FAIL dwell_hold step %0d: got %h want 7f", s, X); end
            n_cmp++;
            if (pending !== PW'(1)) begin n_fail++; $display("FAIL dwell_pend step %0d: got %0d want 1", s, pending); end
            if (s == 1 || s == 3) scan_tick = 1'b1;
            cycle();
        end
        n_cmp++;
        if (X !== 8'hFF) begin n_fail++; $display("FAIL dwell_release: got %h want ff", X); end
        n_cmp++;
        if (pending !== '0) begin n_fail++; $display("FAIL dwell_pend_end: got %0d want 0", pending); end
    endtask

    task automatic test_redundant();
        do_reset();
        Y = 4'd3;
        offer(3, 3, 1'b1);
        cycle();
        offer(3, 3, 1'b1);
        cycle();
        n_cmp++;
        if (X !== 8'hF7) begin n_fail++; $display("FAIL redund_first: got %h want f7", X); end
        scan_tick = 1'b1;
        cycle();
        scan_tick = 1'b1;
        cycle();
        n_cmp++;
        if (pending !== PW'(1)) begin n_fail++; $display("FAIL redund_pend_dwell_end: got %0d want 1", pending); end
        cycle();
        n_cmp++;
        if (pending !== '0) begin n_fail++; $display("FAIL redund_pend_after: got %0d want 0", pending); end
        // No dwell from the redundant pop: a release goes straight through.
        offer(3, 3, 1'b0);
        cycle();
        cycle();
        n_cmp++;
        if (X !== 8'hFF) begin n_fail++; $display("FAIL redund_no_dwell: got %h want ff", X); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            offer(i, i % COLS, 1'b1);
            cycle();
            n_cmp++;
            if (ev_ready !== (m_q.size() < DEPTH)) begin
                n_fail++;
                $display("FAIL ovf_ready ev %0d: got %b want %b", i, ev_ready, m_q.size() < DEPTH);
            end
        end
        n_cmp++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        n_cmp++;
        if (pending !== PW'(DEPTH)) begin n_fail++; $display("FAIL ovf_pend_full: got %0d want %0d", pending, DEPTH); end
        for (int i = 0; i < 40; i++) begin
            scan_tick = 1'b1;
            cycle();
        end
        n_cmp++;
        if (pending !== '0) begin n_fail++; $display("FAIL ovf_drain: got %0d want 0", pending); end
        Y = 4'd9; #1;
        n_cmp++;
        if (X !== 8'hFF) begin n_fail++; $display("FAIL ovf_dropped_ev: got %h want ff", X); end
        for (int r = 0; r < ROWS; r++) begin
            Y = RW'(r); #1;
            n_cmp++;
            if (X !== ~m_mat[r]) begin n_fail++; $display("FAIL ovf_X row %0d: got %h want %h", r, X, ~m_mat[r]); end
        end
    endtask

    task automatic test_release_all();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            offer(i, 0, 1'b1);
            cycle();
        end
        n_cmp++;
        if (pending !== PW'(4)) begin n_fail++; $display("FAIL rel_pend_before: got %0d want 4", pending); end
        release_all = 1'b1;
        cycle();
        n_cmp++;
        if (pending !== '0) begin n_fail++; $display("FAIL rel_pend: got %0d want 0", pending); end
        n_cmp++;
        if (ev_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %b want 1", ev_ready); end
        n_cmp++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL rel_overflow: got %b want 0", overflow); end
        for (int r = 0; r < ROWS; r++) begin
            Y = RW'(r); #1;
            n_cmp++;
            if (X !== 8'hFF) begin n_fail++; $display("FAIL rel_X row %0d: got %h want ff", r, X); end
        end
        offer(6, 2, 1'b1);
        cycle();
        cycle();
        Y = 4'd6; #1;
        n_cmp++;
        if (X !== 8'hFB) begin n_fail++; $display("FAIL rel_idle_after: got %h want fb", X); end
    endtask

    task automatic test_reset_mid_dwell();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            offer(i, 1, 1'b1);
            cycle();
        end
        n_cmp++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL rst_pre_overflow: got %b want 1", overflow); end
        reset = 1'b1;
        cycle();
        n_cmp++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        n_cmp++;
        if (pending !== '0) begin n_fail++; $display("FAIL rst_pend: got %0d want 0", pending); end
        for (int r = 0; r < ROWS; r++) begin
            Y = RW'(r); #1;
            n_cmp++;
            if (X !== 8'hFF) begin n_fail++; $display("FAIL rst_X row %0d: got %h want ff", r, X); end
        end
        offer(11, 4, 1'b1);
        cycle();
        Y = 4'd11; #1;
        n_cmp++;
        if (X !== 8'hFF) begin n_fail++; $display("FAIL rst_new_early: got %h want ff", X); end
        cycle();
        n_cmp++;
        if (X !== 8'hEF) begin n_fail++; $display("FAIL rst_new_press: got %h want ef", X); end
    endtask

    task automatic test_random();
        int ry;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 499) == 0);
            release_all = ($urandom_range(0, 63) == 0);
            scan_tick   = ($urandom_range(0, 3) == 0);
            ev_valid    = $urandom_range(0, 1);
            ev_press    = $urandom_range(0, 1);
            ev_row      = $urandom_range(0, 1) ? RW'($urandom_range(0, 3)) : RW'($urandom_range(0, ROWS - 1));
            ev_col      = $urandom_range(0, 1) ? CW'($urandom_range(0, 1)) : CW'($urandom_range(0, COLS - 1));
            cycle();
            n_cmp++;
            if (pending !== PW'(m_q.size())) begin n_fail++; $display("FAIL rnd_pend cyc %0d: got %0d want %0d", n, pending, m_q.size()); end
            n_cmp++;
            if (ev_ready !== (m_q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready cyc %0d: got %b want %b", n, ev_ready, m_q.size() < DEPTH); end
            n_cmp++;
            if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow cyc %0d: got %b want %b", n, overflow, m_ovf); end
            ry = $urandom_range(0, ROWS - 1);
            Y = RW'(ry); #1;
            n_cmp++;
            if (X !== ~m_mat[ry]) begin n_fail++; $display("FAIL rnd_X cyc %0d row %0d: got %h want %h", n, ry, X, ~m_mat[ry]); end
        end
    endtask

    initial begin
        reset       = 1'b1;
        ev_valid    = 1'b0;
        ev_press    = 1'b0;
        ev_row      = '0;
        ev_col      = '0;
        scan_tick   = 1'b0;
        release_all = 1'b0;
        Y           = '0;
        m_dwell     = 0;
        m_ovf       = 1'b0;
        for (int i = 0; i < ROWS; i++) m_mat[i] = '0;
        @(negedge clk);
        test_reset();
        test_single_press();
        test_dwell_pacing();
        test_redundant();
        test_overflow();
        test_release_all();
        test_reset_mid_dwell();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
